// File: rtl/axi_10g_rx_dispatch.sv
// rtl/axi_10g_rx_dispatch.sv - RX frame classifier and cut-through dispatcher for the 10G MAC
//
// Looks at the first three beats of every frame from the MAC RX stream and
// classifies the frame as ARP, ICMPv4, TCPv4 or DROP. It then forwards the
// whole frame on one shared output bus, with one tvalid per receive path.
// A 4-entry FIFO holds the header beats while the class is being decided.
//
// Optional feature macro: RX_STATS_EN adds the stat_* frame counters.
//
// Ports:
//   aclk, areset_n      clock, asynchronous active-low reset
//   local_mac           station MAC, first wire byte in [47:40]
//   rx_axis_*           MAC RX stream (tdata/tkeep/tvalid/tlast/tuser), no tready
//   stat_*              saturating frame counters (RX_STATS_EN only)
//   m_tdata/tkeep/tlast/tuser  shared output bus, zero when nothing is popped
//   arp/icmp/tcp_rx_tvalid     per-path beat valid
//   arp_rx_is_req       ARP oper==1, held for the whole frame
module axi_10g_rx_dispatch #(
  parameter int CHECK_DST_MAC = 1,
  parameter int SHOW_DROP     = 0
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic [47:0] local_mac,
  input  logic [63:0] rx_axis_tdata,
  input  logic [7:0]  rx_axis_tkeep,
  input  logic        rx_axis_tvalid,
  input  logic        rx_axis_tlast,
  input  logic        rx_axis_tuser,
`ifdef RX_STATS_EN
  output logic [31:0] stat_arp,
  output logic [31:0] stat_icmp,
  output logic [31:0] stat_tcp,
  output logic [31:0] stat_drop,
`endif
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        arp_rx_tvalid,
  output logic        arp_rx_is_req,
  output logic        icmp_rx_tvalid,
  output logic        tcp_rx_tvalid
);

  localparam logic [1:0] CLS_DROP = 2'd0;
  localparam logic [1:0] CLS_ARP  = 2'd1;
  localparam logic [1:0] CLS_ICMP = 2'd2;
  localparam logic [1:0] CLS_TCP  = 2'd3;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_FWD  = 1'b1;

  // beat FIFO
  logic [63:0] fifo_data [4];
  logic [7:0]  fifo_keep [4];
  logic [3:0]  fifo_last;
  logic [3:0]  fifo_user;
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        pop;
  logic        latch;

  // header tracking and classification
  logic [1:0]  hcnt;
  logic        dst_ok;
  logic [15:0] ethertype;
  logic [7:0]  ver_ihl;
  logic        dst_match;
  logic [15:0] oper;
  logic [7:0]  proto;
  logic        new_vld;
  logic [1:0]  new_cls;
  logic        new_is_req;

  // pending class (next frame) and latched class (frame being forwarded)
  logic [1:0]  cls;
  logic        is_req;
  logic        cls_vld;
  logic [1:0]  cur_cls;
  logic        cur_is_req;
  logic [1:0]  pop_cls;
  logic [0:0]  state;

  always_ff @(posedge aclk) begin
    if (rx_axis_tvalid) begin
      fifo_data[wr_ptr] <= rx_axis_tdata;
      fifo_keep[wr_ptr] <= rx_axis_tkeep;
      fifo_last[wr_ptr] <= rx_axis_tlast;
      fifo_user[wr_ptr] <= rx_axis_tuser;
    end
  end

  // The WAIT->FWD transition pops beat0 in the same cycle as the class is latched.
  assign latch = (state == ST_WAIT) && cls_vld && (count != 3'd0);
  assign pop   = latch || ((state == ST_FWD) && (count != 3'd0));

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (rx_axis_tvalid) wr_ptr <= wr_ptr + 2'd1;
      if (pop)            rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, rx_axis_tvalid} - {2'b00, pop};
    end
  end

  // local_mac holds the first wire byte in its MSB; tdata holds it in the LSB.
  assign dst_match = (CHECK_DST_MAC == 0) ||
                     (rx_axis_tdata[47:0] == 48'hffff_ffff_ffff) ||
                     (rx_axis_tdata[47:0] == {local_mac[7:0],   local_mac[15:8],
                                              local_mac[23:16], local_mac[31:24],
                                              local_mac[39:32], local_mac[47:40]});
  assign oper  = {rx_axis_tdata[39:32], rx_axis_tdata[47:40]};
  assign proto = rx_axis_tdata[63:56];

  always_comb begin
    new_vld    = 1'b0;
    new_cls    = CLS_DROP;
    new_is_req = 1'b0;
    if (rx_axis_tvalid) begin
      if (hcnt == 2'd2) begin
        new_vld = 1'b1;
        if (!dst_ok) begin
          new_cls = CLS_DROP;
        end else if ((ethertype == 16'h0806) && ((oper == 16'd1) || (oper == 16'd2))) begin
          new_cls    = CLS_ARP;
          new_is_req = (oper == 16'd1);
        end else if ((ethertype == 16'h0800) && (ver_ihl == 8'h45) && (proto == 8'd1)) begin
          new_cls = CLS_ICMP;
        end else if ((ethertype == 16'h0800) && (ver_ihl == 8'h45) && (proto == 8'd6)) begin
          new_cls = CLS_TCP;
        end
      end else if (rx_axis_tlast && (hcnt < 2'd2)) begin
        // runt: no beat2 will ever come, decide now so the FIFO drains
        new_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      hcnt      <= 2'd0;
      dst_ok    <= 1'b0;
      ethertype <= 16'd0;
      ver_ihl   <= 8'd0;
    end else if (rx_axis_tvalid) begin
      if (rx_axis_tlast)      hcnt <= 2'd0;
      else if (hcnt != 2'd3)  hcnt <= hcnt + 2'd1;
      if (hcnt == 2'd0) dst_ok <= dst_match;
      if (hcnt == 2'd1) begin
        ethertype <= {rx_axis_tdata[39:32], rx_axis_tdata[47:40]};
        ver_ihl   <= rx_axis_tdata[55:48];
      end
    end
  end

  // A new classification always wins over the clear from latching the previous one.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      cls     <= CLS_DROP;
      is_req  <= 1'b0;
      cls_vld <= 1'b0;
    end else if (new_vld) begin
      cls     <= new_cls;
      is_req  <= new_is_req;
      cls_vld <= 1'b1;
    end else if (latch) begin
      cls_vld <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= ST_WAIT;
      cur_cls    <= CLS_DROP;
      cur_is_req <= 1'b0;
    end else if (latch) begin
      cur_cls    <= cls;
      cur_is_req <= is_req;
      state      <= fifo_last[rd_ptr] ? ST_WAIT : ST_FWD;
    end else if ((state == ST_FWD) && pop && fifo_last[rd_ptr]) begin
      state <= ST_WAIT;
    end
  end

  assign pop_cls       = latch ? cls : cur_cls;
  assign arp_rx_is_req = cur_is_req;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      m_tdata        <= 64'd0;
      m_tkeep        <= 8'd0;
      m_tlast        <= 1'b0;
      m_tuser        <= 1'b0;
      arp_rx_tvalid  <= 1'b0;
      icmp_rx_tvalid <= 1'b0;
      tcp_rx_tvalid  <= 1'b0;
    end else if (pop) begin
      m_tdata        <= fifo_data[rd_ptr];
      m_tkeep        <= fifo_keep[rd_ptr];
      m_tlast        <= fifo_last[rd_ptr];
      m_tuser        <= fifo_user[rd_ptr];
      arp_rx_tvalid  <= (pop_cls == CLS_ARP);
      icmp_rx_tvalid <= (pop_cls == CLS_ICMP);
      tcp_rx_tvalid  <= (pop_cls == CLS_TCP);
    end else begin
      m_tdata        <= 64'd0;
      m_tkeep        <= 8'd0;
      m_tlast        <= 1'b0;
      m_tuser        <= 1'b0;
      arp_rx_tvalid  <= 1'b0;
      icmp_rx_tvalid <= 1'b0;
      tcp_rx_tvalid  <= 1'b0;
    end
  end

`ifdef RX_STATS_EN
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      stat_arp  <= 32'd0;
      stat_icmp <= 32'd0;
      stat_tcp  <= 32'd0;
      stat_drop <= 32'd0;
    end else if (latch) begin
      case (cls)
        CLS_ARP:  if (stat_arp  != 32'hffff_ffff) stat_arp  <= stat_arp  + 32'd1;
        CLS_ICMP: if (stat_icmp != 32'hffff_ffff) stat_icmp <= stat_icmp + 32'd1;
        CLS_TCP:  if (stat_tcp  != 32'hffff_ffff) stat_tcp  <= stat_tcp  + 32'd1;
        default:  if (stat_drop != 32'hffff_ffff) stat_drop <= stat_drop + 32'd1;
      endcase
    end
  end
`endif

`ifndef SYNTHESIS
  // Input cannot be back-pressured, so an overflow means the latency budget was broken.
  always @(posedge aclk) begin
    if (areset_n) begin
      assert (count <= 3'd3) else $error("rx_dispatch: beat FIFO overflow, count=%0d", count);
      if ((SHOW_DROP != 0) && latch && (cls == CLS_DROP))
        $display("rx_dispatch drop: cls=%0d beat0=%016h", cls, fifo_data[rd_ptr]);
    end
  end
`endif

endmodule

// File: tb/tb_axi_10g_rx_dispatch.sv
// tb/tb_axi_10g_rx_dispatch.sv - directed bench for axi_10g_rx_dispatch with frame-level model
module tb_axi_10g_rx_dispatch;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [47:0] local_mac;
  logic [63:0] rx_axis_tdata;
  logic [7:0]  rx_axis_tkeep;
  logic        rx_axis_tvalid;
  logic        rx_axis_tlast;
  logic        rx_axis_tuser;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tuser;
  logic        arp_rx_tvalid;
  logic        arp_rx_is_req;
  logic        icmp_rx_tvalid;
  logic        tcp_rx_tvalid;
`ifdef RX_STATS_EN
  logic [31:0] stat_arp, stat_icmp, stat_tcp, stat_drop;
`endif

  always #5 aclk = ~aclk;

  axi_10g_rx_dispatch #(.CHECK_DST_MAC(1), .SHOW_DROP(0)) dut (
    .aclk(aclk),
    .areset_n(areset_n),
    .local_mac(local_mac),
    .rx_axis_tdata(rx_axis_tdata),
    .rx_axis_tkeep(rx_axis_tkeep),
    .rx_axis_tvalid(rx_axis_tvalid),
    .rx_axis_tlast(rx_axis_tlast),
    .rx_axis_tuser(rx_axis_tuser),
`ifdef RX_STATS_EN
    .stat_arp(stat_arp),
    .stat_icmp(stat_icmp),
    .stat_tcp(stat_tcp),
    .stat_drop(stat_drop),
`endif
    .m_tdata(m_tdata),
    .m_tkeep(m_tkeep),
    .m_tlast(m_tlast),
    .m_tuser(m_tuser),
    .arp_rx_tvalid(arp_rx_tvalid),
    .arp_rx_is_req(arp_rx_is_req),
    .icmp_rx_tvalid(icmp_rx_tvalid),
    .tcp_rx_tvalid(tcp_rx_tvalid)
  );

  typedef struct {
    logic [1:0]  path;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic        is_req;
    int          in_cyc;
    bit          first;
    bit          chk_lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fr[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int beats_arp = 0, beats_icmp = 0, beats_tcp = 0, n_runs = 0;
  int prev_v_cyc = -10;
  int first_lat = 0;
  logic [7:0] last_keep = 8'd0;
  logic       last_user = 1'b0;
  logic       last_arp_req = 1'b0;
  int ms_arp = 0, ms_icmp = 0, ms_tcp = 0, ms_drop = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Classification straight from frame bytes: returns {is_req, path}, path 0=drop 1=arp 2=icmp 3=tcp.
  function automatic logic [2:0] model_class();
    logic [7:0]  b [24];
    bit          bc, uc;
    logic [15:0] et, op;
    for (int i = 0; i < 24; i++) b[i] = (i < fr.size()) ? fr[i] : 8'd0;
    if (fr.size() <= 16) return 3'b000;
    bc = 1; uc = 1;
    for (int k = 0; k < 6; k++) begin
      if (b[k] != 8'hff) bc = 0;
      if (b[k] != local_mac[47-8*k -: 8]) uc = 0;
    end
    if (!(bc || uc)) return 3'b000;
    et = {b[12], b[13]};
    op = {b[20], b[21]};
    if (et == 16'h0806 && (op == 16'd1 || op == 16'd2)) return {op == 16'd1, 2'd1};
    if (et == 16'h0800 && b[14] == 8'h45 && b[23] == 8'd1) return 3'b010;
    if (et == 16'h0800 && b[14] == 8'h45 && b[23] == 8'd6) return 3'b011;
    return 3'b000;
  endfunction

  task automatic build_eth(input logic [47:0] dst, input logic [15:0] et, input int len, input int seed);
    fr.delete();
    for (int i = 0; i < len; i++) fr.push_back(8'((i * 7 + seed) & 255));
    for (int k = 0; k < 6; k++) fr[k] = dst[47-8*k -: 8];
    for (int k = 0; k < 6; k++) fr[6+k] = 8'(8'h10 + k);
    fr[12] = et[15:8];
    fr[13] = et[7:0];
  endtask

  task automatic set_ipv4(input logic [7:0] proto);
    fr[14] = 8'h45;
    fr[23] = proto;
  endtask

  task automatic set_arp(input logic [15:0] oper);
    fr[14] = 8'h00; fr[15] = 8'h01; fr[16] = 8'h08;
    fr[17] = 8'h00; fr[18] = 8'h06; fr[19] = 8'h04;
    fr[20] = oper[15:8];
    fr[21] = oper[7:0];
  endtask

  task automatic idle();
    @(posedge aclk); #1;
    rx_axis_tvalid = 1'b0;
    rx_axis_tdata  = 64'd0;
    rx_axis_tkeep  = 8'd0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
  endtask

  // Drives up to max_beats beats of fr; expects the first max_out of them on the output.
  task automatic send_frame(input logic fcs, input bit gaps, input bit chk_lat,
                            input int max_beats, input int max_out);
    logic [2:0]  mc;
    int          nb;
    exp_t        e;
    logic [63:0] d;
    logic [7:0]  k;
    mc = model_class();
    case (mc[1:0])
      2'd1:    ms_arp++;
      2'd2:    ms_icmp++;
      2'd3:    ms_tcp++;
      default: ms_drop++;
    endcase
    nb = (fr.size() + 7) / 8;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      d = 64'd0;
      k = 8'd0;
      for (int j = 0; j < 8; j++)
        if (b * 8 + j < fr.size()) begin
          d[j*8 +: 8] = fr[b*8+j];
          k[j] = 1'b1;
        end
      @(posedge aclk); #1;
      rx_axis_tvalid = 1'b1;
      rx_axis_tdata  = d;
      rx_axis_tkeep  = k;
      rx_axis_tlast  = (b == nb - 1);
      rx_axis_tuser  = (b == nb - 1) ? fcs : 1'b0;
      if (mc[1:0] != 2'd0 && b < max_out) begin
        e.path = mc[1:0]; e.data = d; e.keep = k;
        e.last = (b == nb - 1); e.user = fcs; e.is_req = mc[2];
        e.in_cyc = cyc + 1; e.first = (b == 0); e.chk_lat = chk_lat;
        exp_q.push_back(e);
      end
      if (gaps && b != nb - 1) idle();
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge aclk);
      t++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    repeat (8) @(posedge aclk);
  endtask

  // Output monitor: every tvalid beat must be the next beat the model predicts.
  always @(negedge aclk) begin
    int         nv;
    logic [1:0] path;
    exp_t       e;
    nv = int'(arp_rx_tvalid) + int'(icmp_rx_tvalid) + int'(tcp_rx_tvalid);
    if (!areset_n) begin
      check("rst_data", m_tdata, 64'd0);
      check("rst_ctl", 64'({m_tkeep, m_tlast, m_tuser, arp_rx_tvalid, arp_rx_is_req,
                            icmp_rx_tvalid, tcp_rx_tvalid}), 64'd0);
    end else if (nv != 0) begin
      check("tvalid_onehot", 64'(nv), 64'd1);
      path = arp_rx_tvalid ? 2'd1 : (icmp_rx_tvalid ? 2'd2 : 2'd3);
      if (prev_v_cyc != cyc - 1) n_runs++;
      prev_v_cyc = cyc;
      if (path == 2'd1) beats_arp++;
      if (path == 2'd2) beats_icmp++;
      if (path == 2'd3) beats_tcp++;
      if (m_tlast) begin
        last_keep = m_tkeep;
        last_user = m_tuser;
      end
      if (path == 2'd1) last_arp_req = arp_rx_is_req;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(nv), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("path", 64'(path), 64'(e.path));
        check("tdata", m_tdata, e.data);
        check("tkeep", 64'(m_tkeep), 64'(e.keep));
        check("tlast", 64'(m_tlast), 64'(e.last));
        if (e.last) check("tuser", 64'(m_tuser), 64'(e.user));
        if (path == 2'd1) check("is_req", 64'(arp_rx_is_req), 64'(e.is_req));
        if (e.chk_lat) check("latency", 64'(cyc - e.in_cyc), 64'd3);
        if (e.first) first_lat = cyc - e.in_cyc;
      end
    end
  end

  initial begin
    logic [2:0] mc;
    int a0, i0, t0, r0, tot0;
    areset_n       = 1'b0;
    local_mac      = 48'h000a35010203;
    rx_axis_tvalid = 1'b0;
    rx_axis_tdata  = 64'd0;
    rx_axis_tkeep  = 8'd0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
    repeat (4) @(posedge aclk);
    #1 areset_n = 1'b1;
    @(negedge aclk);
    check("reset_m_tdata", m_tdata, 64'd0);
    check("reset_valids", 64'({arp_rx_tvalid, icmp_rx_tvalid, tcp_rx_tvalid, arp_rx_is_req, m_tlast}), 64'd0);

    // ARP request, broadcast, 64 bytes
    build_eth(48'hffff_ffff_ffff, 16'h0806, 64, 3);
    set_arp(16'd1);
    mc = model_class();
    check("arp_model", 64'(mc), 64'(3'b101));
    a0 = beats_arp;
    send_frame(1'b1, 1'b0, 1'b1, 99, 99);
    idle();
    drain();
    check("arp_beats", 64'(beats_arp - a0), 64'd8);
    check("arp_first_lat", 64'(first_lat), 64'd3);
    check("arp_is_req", 64'(last_arp_req), 64'd1);

    // ICMP echo, unicast, 98 bytes
    build_eth(48'h000a35010203, 16'h0800, 98, 5);
    set_ipv4(8'd1);
    mc = model_class();
    check("icmp_model", 64'(mc), 64'(3'b010));
    i0 = beats_icmp;
    send_frame(1'b1, 1'b0, 1'b1, 99, 99);
    idle();
    drain();
    check("icmp_beats", 64'(beats_icmp - i0), 64'd13);
    check("icmp_last_keep", 64'(last_keep), 64'h03);
    check("icmp_last_user", 64'(last_user), 64'd1);

    // TCP (bad FCS) then ICMP back to back
    t0 = beats_tcp; i0 = beats_icmp; r0 = n_runs;
    build_eth(48'h000a35010203, 16'h0800, 70, 9);
    set_ipv4(8'd6);
    mc = model_class();
    check("tcp_model", 64'(mc), 64'(3'b011));
    send_frame(1'b0, 1'b0, 1'b1, 99, 99);
    build_eth(48'hffff_ffff_ffff, 16'h0800, 64, 11);
    set_ipv4(8'd1);
    send_frame(1'b1, 1'b0, 1'b1, 99, 99);
    idle();
    drain();
    check("b2b_tcp_beats", 64'(beats_tcp - t0), 64'd9);
    check("b2b_icmp_beats", 64'(beats_icmp - i0), 64'd8);
    check("b2b_contiguous", 64'(n_runs - r0), 64'd1);
`ifdef RX_STATS_EN
    check("stat_arp_1", 64'(stat_arp), 64'd1);
    check("stat_icmp_2", 64'(stat_icmp), 64'd2);
    check("stat_tcp_1", 64'(stat_tcp), 64'd1);
    check("stat_drop_0", 64'(stat_drop), 64'd0);
`endif

    // IPv6, UDP, foreign unicast: all dropped
    tot0 = beats_arp + beats_icmp + beats_tcp;
    build_eth(48'hffff_ffff_ffff, 16'h86dd, 80, 13);
    fr[14] = 8'h60;
    mc = model_class();
    check("ipv6_model", 64'(mc), 64'd0);
    send_frame(1'b1, 1'b0, 1'b0, 99, 99);
    idle();
    build_eth(48'h000a35010203, 16'h0800, 64, 15);
    set_ipv4(8'd17);
    mc = model_class();
    check("udp_model", 64'(mc), 64'd0);
    send_frame(1'b1, 1'b0, 1'b0, 99, 99);
    idle();
    build_eth(48'h001122334455, 16'h0800, 64, 17);
    set_ipv4(8'd6);
    mc = model_class();
    check("foreign_model", 64'(mc), 64'd0);
    send_frame(1'b1, 1'b0, 1'b0, 99, 99);
    idle();
    drain();
    check("drop_no_tvalid", 64'(beats_arp + beats_icmp + beats_tcp - tot0), 64'd0);
`ifdef RX_STATS_EN
    check("stat_drop_3", 64'(stat_drop), 64'd3);
`endif

    // 2-beat runt, then TCP with a gap after every beat
    tot0 = beats_arp + beats_icmp + beats_tcp;
    t0 = beats_tcp;
    build_eth(48'h000a35010203, 16'h0800, 16, 19);
    fr[14] = 8'h45;
    mc = model_class();
    check("runt_model", 64'(mc), 64'd0);
    send_frame(1'b1, 1'b0, 1'b0, 99, 99);
    build_eth(48'h000a35010203, 16'h0800, 72, 21);
    set_ipv4(8'd6);
    send_frame(1'b1, 1'b1, 1'b0, 99, 99);
    idle();
    drain();
    check("gap_tcp_beats", 64'(beats_tcp - t0), 64'd9);
    check("gap_total_beats", 64'(beats_arp + beats_icmp + beats_tcp - tot0), 64'd9);
    check("gap_last_keep", 64'(last_keep), 64'hff);
`ifdef RX_STATS_EN
    check("stat_drop_4", 64'(stat_drop), 64'd4);
    check("stat_tcp_2", 64'(stat_tcp), 64'd2);
`endif

    // Reset in the middle of a TCP frame, then an ARP reply
    t0 = beats_tcp;
    build_eth(48'h000a35010203, 16'h0800, 80, 23);
    set_ipv4(8'd6);
    send_frame(1'b1, 1'b0, 1'b1, 4, 1);
    @(posedge aclk);
    @(negedge aclk);
    #1;
    areset_n       = 1'b0;
    rx_axis_tvalid = 1'b0;
    rx_axis_tdata  = 64'd0;
    rx_axis_tkeep  = 8'd0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
    ms_arp = 0; ms_icmp = 0; ms_tcp = 0; ms_drop = 0;
    check("abort_q_empty", 64'(exp_q.size()), 64'd0);
    check("abort_tcp_beats", 64'(beats_tcp - t0), 64'd1);
    repeat (3) @(posedge aclk);
    #1 areset_n = 1'b1;
    a0 = beats_arp;
    build_eth(48'h000a35010203, 16'h0806, 60, 25);
    set_arp(16'd2);
    mc = model_class();
    check("arp_reply_model", 64'(mc), 64'(3'b001));
    send_frame(1'b1, 1'b0, 1'b1, 99, 99);
    idle();
    drain();
    check("arp_reply_beats", 64'(beats_arp - a0), 64'd8);
    check("arp_reply_is_req", 64'(last_arp_req), 64'd0);
    check("arp_reply_last_keep", 64'(last_keep), 64'h0f);
`ifdef RX_STATS_EN
    check("stat_arp_after_rst", 64'(stat_arp), 64'(ms_arp));
    check("stat_tcp_after_rst", 64'(stat_tcp), 64'd0);
    check("stat_drop_after_rst", 64'(stat_drop), 64'd0);
`endif

    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
